// File: rtl/fifo_sig_pkg.sv
// Shared constants, typedefs and helpers for the multi-channel runtime-configured FIFO.
package fifo_sig_pkg;

    // Bit n set means n is a legal runtime depth (2, 4, 8).
    localparam logic [15:0] DEPTH_LEGAL = 16'h0114;
    localparam int unsigned DEPTH_MAX   = 8;
    localparam int unsigned WIDTH_MIN   = 8;
    localparam int unsigned WIDTH_MAX   = 11;
    localparam int unsigned CH_MAX      = 8;

    localparam int unsigned PTR_W = $clog2(DEPTH_MAX);
    localparam int unsigned CNT_W = $clog2(DEPTH_MAX + 1);
    localparam int unsigned CH_W  = $clog2(CH_MAX);

    typedef logic [CH_W-1:0]  ch_idx_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Ones in the low 'width' bits; upper bits of a stored word are forced to zero.
    function automatic logic [WIDTH_MAX-1:0] width_mask(input logic [3:0] width);
        logic [WIDTH_MAX-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < WIDTH_MAX; i++) begin
            mask[i] = (i < 32'(width));
        end
        return mask;
    endfunction

endpackage

// File: rtl/fifo_ch_ctrl.sv
// Per-channel pointer, count, flag and sticky-error bookkeeping for one FIFO channel.
module fifo_ch_ctrl
    import fifo_sig_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_en,
    input  logic             pop_en,
    input  logic             err_clr,
    input  logic [3:0]       sig_FIFO_DEPTH,
    input  logic [3:0]       sig_AFULL_THR,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic             push_ok_c,
    output logic             pop_ok_c,
    output logic             empty_c,
    output logic             full_c,
    output logic             afull_c,
    output logic             ovf_err,
    output logic             udf_err
);

    cnt_t count;
    cnt_t count_nxt;
    ptr_t wr_ptr_nxt;
    ptr_t rd_ptr_nxt;
    ptr_t last_ptr;
    logic ovf_nxt;
    logic udf_nxt;

    function automatic ptr_t wrap_inc(input ptr_t p, input ptr_t last);
        return (p == last) ? '0 : p + ptr_t'(1);
    endfunction

    assign last_ptr  = ptr_t'(sig_FIFO_DEPTH - 4'd1);
    assign empty_c   = (count == '0);
    assign full_c    = (count == cnt_t'(sig_FIFO_DEPTH));
    assign afull_c   = (count >= cnt_t'(sig_AFULL_THR));
    assign pop_ok_c  = pop_en && !empty_c;
    // A pop in the same cycle frees the slot a full channel needs.
    assign push_ok_c = push_en && (!full_c || pop_ok_c);

    // Next-state for count, pointers and sticky errors; clear wins over set.
    always_comb begin
        count_nxt  = count;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        ovf_nxt    = ovf_err;
        udf_nxt    = udf_err;
        if (push_ok_c && !pop_ok_c) begin
            count_nxt = count + cnt_t'(1);
        end else if (!push_ok_c && pop_ok_c) begin
            count_nxt = count - cnt_t'(1);
        end
        if (push_ok_c) begin
            wr_ptr_nxt = wrap_inc(wr_ptr, last_ptr);
        end
        if (pop_ok_c) begin
            rd_ptr_nxt = wrap_inc(rd_ptr, last_ptr);
        end
        if (push_en && !push_ok_c) begin
            ovf_nxt = 1'b1;
        end
        if (pop_en && empty_c) begin
            udf_nxt = 1'b1;
        end
        if (err_clr) begin
            ovf_nxt = 1'b0;
            udf_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            count   <= count_nxt;
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            ovf_err <= ovf_nxt;
            udf_err <= udf_nxt;
        end
    end

endmodule

// File: rtl/fifo_mch_sig.sv
// NUM_CH independent runtime-sized FIFOs behind one shared push port and one registered pop port.
module fifo_mch_sig
    import fifo_sig_pkg::*;
#(
    parameter int unsigned max_FIFO_DEPTH = 8,
    parameter int unsigned max_FIFO_WIDTH = 11,
    parameter int unsigned NUM_CH         = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        push,
    input  logic [$clog2(NUM_CH)-1:0]   push_ch,
    input  logic [max_FIFO_WIDTH-1:0]   push_data,
    input  logic                        pop,
    input  logic [$clog2(NUM_CH)-1:0]   pop_ch,
    output logic [max_FIFO_WIDTH-1:0]   pop_data,
    output logic                        pop_valid,
    output logic [NUM_CH-1:0]           empty,
    output logic [NUM_CH-1:0]           full,
    output logic [NUM_CH-1:0]           afull,
    output logic [NUM_CH-1:0]           ovf_err,
    output logic [NUM_CH-1:0]           udf_err,
    input  logic                        err_clr,
    input  logic [3:0]                  sig_FIFO_DEPTH,
    input  logic [3:0]                  sig_FIFO_WIDTH,
    input  logic [3:0]                  sig_AFULL_THR
);

    localparam int unsigned W = max_FIFO_WIDTH;

    logic [W-1:0]      mem [NUM_CH][max_FIFO_DEPTH];
    ptr_t              wr_ptr [NUM_CH];
    ptr_t              rd_ptr [NUM_CH];
    logic [NUM_CH-1:0] push_ok;
    logic [NUM_CH-1:0] pop_ok;
    logic [W-1:0]      wmask;
    ch_idx_t           push_idx;
    ch_idx_t           pop_idx;

    assign wmask    = W'(width_mask(sig_FIFO_WIDTH));
    assign push_idx = ch_idx_t'(push_ch);
    assign pop_idx  = ch_idx_t'(pop_ch);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        fifo_ch_ctrl u_ctrl (
            .clk            (clk),
            .rstn           (rstn),
            .push_en        (push && (push_idx == ch_idx_t'(c))),
            .pop_en         (pop && (pop_idx == ch_idx_t'(c))),
            .err_clr        (err_clr),
            .sig_FIFO_DEPTH (sig_FIFO_DEPTH),
            .sig_AFULL_THR  (sig_AFULL_THR),
            .wr_ptr         (wr_ptr[c]),
            .rd_ptr         (rd_ptr[c]),
            .push_ok_c      (push_ok[c]),
            .pop_ok_c       (pop_ok[c]),
            .empty_c        (empty[c]),
            .full_c         (full[c]),
            .afull_c        (afull[c]),
            .ovf_err        (ovf_err[c]),
            .udf_err        (udf_err[c])
        );
    end

    // Storage needs no reset: contents are only observable through accepted pops.
    always_ff @(posedge clk) begin
        if (|push_ok) begin
            mem[push_ch][wr_ptr[push_ch]] <= push_data & wmask;
        end
    end

    // Read data register; the old word is read even when a same-cycle push overwrites its slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else begin
            pop_valid <= |pop_ok;
            if (|pop_ok) begin
                pop_data <= mem[pop_ch][rd_ptr[pop_ch]];
            end
        end
    end

    // Runtime configuration must be legal and static while out of reset.
    a_cfg_legal: assume property (@(posedge clk) disable iff (!rstn)
        DEPTH_LEGAL[sig_FIFO_DEPTH] && (32'(sig_FIFO_DEPTH) <= max_FIFO_DEPTH) &&
        (sig_FIFO_WIDTH >= 4'(WIDTH_MIN)) && (32'(sig_FIFO_WIDTH) <= max_FIFO_WIDTH) &&
        (sig_AFULL_THR != 4'd0) && (sig_AFULL_THR <= sig_FIFO_DEPTH));

    a_cfg_stable: assume property (@(posedge clk) disable iff (!rstn)
        $stable(sig_FIFO_DEPTH) && $stable(sig_FIFO_WIDTH) && $stable(sig_AFULL_THR));

endmodule

// File: tb/tb_fifo_mch_sig.sv
// Directed, table-driven bench for fifo_mch_sig with hand-computed expectations.
module tb_fifo_mch_sig;

    logic        clk;
    logic        rstn;
    logic        push;
    logic [1:0]  push_ch;
    logic [10:0] push_data;
    logic        pop;
    logic [1:0]  pop_ch;
    logic [10:0] pop_data;
    logic        pop_valid;
    logic [3:0]  empty;
    logic [3:0]  full;
    logic [3:0]  afull;
    logic [3:0]  ovf_err;
    logic [3:0]  udf_err;
    logic        err_clr;
    logic [3:0]  sig_FIFO_DEPTH;
    logic [3:0]  sig_FIFO_WIDTH;
    logic [3:0]  sig_AFULL_THR;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        push;
        logic [1:0]  push_ch;
        logic [10:0] push_data;
        logic        pop;
        logic [1:0]  pop_ch;
        logic        clr;
        logic        chk_data;
        logic        exp_valid;
        logic [10:0] exp_data;
        logic [3:0]  exp_empty;
        logic [3:0]  exp_full;
        logic [3:0]  exp_afull;
        logic [3:0]  exp_ovf;
        logic [3:0]  exp_udf;
    } vec_t;

    vec_t vq[$];

    fifo_mch_sig dut (
        .clk            (clk),
        .rstn           (rstn),
        .push           (push),
        .push_ch        (push_ch),
        .push_data      (push_data),
        .pop            (pop),
        .pop_ch         (pop_ch),
        .pop_data       (pop_data),
        .pop_valid      (pop_valid),
        .empty          (empty),
        .full           (full),
        .afull          (afull),
        .ovf_err        (ovf_err),
        .udf_err        (udf_err),
        .err_clr        (err_clr),
        .sig_FIFO_DEPTH (sig_FIFO_DEPTH),
        .sig_FIFO_WIDTH (sig_FIFO_WIDTH),
        .sig_AFULL_THR  (sig_AFULL_THR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic p, input logic [1:0] pc, input logic [10:0] pd,
                                input logic q, input logic [1:0] qc, input logic clr,
                                input logic chk, input logic ev, input logic [10:0] ed,
                                input logic [3:0] ee, input logic [3:0] ef, input logic [3:0] ea,
                                input logic [3:0] eo, input logic [3:0] eu);
        vec_t v;
        v.push = p;  v.push_ch = pc; v.push_data = pd;
        v.pop = q;   v.pop_ch = qc;  v.clr = clr;
        v.chk_data = chk; v.exp_valid = ev; v.exp_data = ed;
        v.exp_empty = ee; v.exp_full = ef; v.exp_afull = ea;
        v.exp_ovf = eo;   v.exp_udf = eu;
        vq.push_back(v);
    endfunction

    task automatic idle();
        push = 1'b0; push_ch = '0; push_data = '0;
        pop = 1'b0;  pop_ch = '0;  err_clr = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic [3:0] ee, input logic [3:0] ef,
                               input logic [3:0] ea, input logic [3:0] eo, input logic [3:0] eu);
        check({tag, " empty"}, 32'(empty), 32'(ee));
        check({tag, " full"},  32'(full),  32'(ef));
        check({tag, " afull"}, 32'(afull), 32'(ea));
        check({tag, " ovf"},   32'(ovf_err), 32'(eo));
        check({tag, " udf"},   32'(udf_err), 32'(eu));
    endtask

    // Apply each queued vector for one clock, then compare just after the edge.
    task automatic run_vectors(input string phase);
        string tag;
        foreach (vq[i]) begin
            push = vq[i].push; push_ch = vq[i].push_ch; push_data = vq[i].push_data;
            pop = vq[i].pop;   pop_ch = vq[i].pop_ch;   err_clr = vq[i].clr;
            @(posedge clk);
            #1;
            tag = $sformatf("%s[%0d]", phase, i);
            check({tag, " pop_valid"}, 32'(pop_valid), 32'(vq[i].exp_valid));
            if (vq[i].chk_data) check({tag, " pop_data"}, 32'(pop_data), 32'(vq[i].exp_data));
            check_flags(tag, vq[i].exp_empty, vq[i].exp_full, vq[i].exp_afull,
                        vq[i].exp_ovf, vq[i].exp_udf);
        end
        idle();
        vq.delete();
    endtask

    task automatic do_reset(input logic [3:0] d, input logic [3:0] w, input logic [3:0] t);
        rstn = 1'b0;
        idle();
        sig_FIFO_DEPTH = d; sig_FIFO_WIDTH = w; sig_AFULL_THR = t;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        sig_FIFO_DEPTH = 4'd4; sig_FIFO_WIDTH = 4'd8; sig_AFULL_THR = 4'd3;

        // Reset state, then width masking at width 8.
        do_reset(4'd4, 4'd8, 4'd3);
        check("reset pop_valid", 32'(pop_valid), 32'd0);
        check("reset pop_data",  32'(pop_data),  32'd0);
        check_flags("reset", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        add(1, 2, 11'h7FF, 0, 0, 0, 0, 0, 11'h0,   4'b1011, 0, 0, 0, 0);
        add(0, 0, 11'h0,   1, 2, 0, 1, 1, 11'h0FF, 4'b1111, 0, 0, 0, 0);
        add(0, 0, 11'h0,   0, 0, 0, 1, 0, 11'h0FF, 4'b1111, 0, 0, 0, 0);
        run_vectors("mask");

        // Fill ch0 past full, drain in order, then clear the overflow bit.
        for (int k = 1; k <= 5; k++)
            add(1, 0, 11'(k), 0, 0, 0, 0, 0, 11'h0, 4'b1110,
                (k >= 4) ? 4'b0001 : 4'b0000, (k >= 3) ? 4'b0001 : 4'b0000,
                (k == 5) ? 4'b0001 : 4'b0000, 4'b0000);
        for (int j = 1; j <= 4; j++)
            add(0, 0, 11'h0, 1, 0, 0, 1, 1, 11'(j), (j == 4) ? 4'b1111 : 4'b1110,
                4'b0000, (4 - j >= 3) ? 4'b0001 : 4'b0000, 4'b0001, 4'b0000);
        add(0, 0, 11'h0, 0, 0, 1, 1, 0, 11'd4, 4'b1111, 0, 0, 0, 0);
        run_vectors("fill");

        // Depth 2: alternating push/pop on ch1 wraps the pointers repeatedly.
        do_reset(4'd2, 4'd11, 4'd2);
        for (int i = 0; i < 10; i++) begin
            add(1, 1, 11'(10 + i), 0, 0, 0, 0, 0, 11'h0, 4'b1101, 0, 0, 0, 0);
            add(0, 0, 11'h0, 1, 1, 0, 1, 1, 11'(10 + i), 4'b1111, 0, 0, 0, 0);
        end
        run_vectors("wrap");

        // Depth 8: push+pop on a full ch3, with a cross-channel push to ch0 during the drain.
        do_reset(4'd8, 4'd11, 4'd4);
        for (int k = 1; k <= 8; k++)
            add(1, 3, 11'(16'h10 + k - 1), 0, 0, 0, 0, 0, 11'h0, 4'b0111,
                (k == 8) ? 4'b1000 : 4'b0000, (k >= 4) ? 4'b1000 : 4'b0000, 0, 0);
        add(1, 3, 11'h55, 1, 3, 0, 1, 1, 11'h10, 4'b0111, 4'b1000, 4'b1000, 0, 0);
        for (int j = 1; j <= 8; j++)
            add((j == 1), 0, 11'h66, 1, 3, 0, 1, 1, (j <= 7) ? 11'(16'h10 + j) : 11'h55,
                (j == 8) ? 4'b1110 : 4'b0110, 4'b0000,
                (8 - j >= 4) ? 4'b1000 : 4'b0000, 0, 0);
        add(0, 0, 11'h0, 1, 0, 0, 1, 1, 11'h66, 4'b1111, 0, 0, 0, 0);
        run_vectors("simul");

        // Underflow, clear, clear-beats-set, and push+pop on an empty channel (no bypass).
        add(0, 0, 11'h0,  1, 1, 0, 1, 0, 11'h66, 4'b1111, 0, 0, 0, 4'b0010);
        add(0, 0, 11'h0,  0, 0, 1, 1, 0, 11'h66, 4'b1111, 0, 0, 0, 4'b0000);
        add(0, 0, 11'h0,  1, 1, 1, 1, 0, 11'h66, 4'b1111, 0, 0, 0, 4'b0000);
        add(0, 0, 11'h0,  0, 0, 0, 1, 0, 11'h66, 4'b1111, 0, 0, 0, 4'b0000);
        add(1, 2, 11'h2A, 1, 2, 0, 1, 0, 11'h66, 4'b1011, 0, 0, 0, 4'b0100);
        add(0, 0, 11'h0,  1, 2, 0, 1, 1, 11'h2A, 4'b1111, 0, 0, 0, 4'b0100);
        add(0, 0, 11'h0,  0, 0, 1, 1, 0, 11'h2A, 4'b1111, 0, 0, 0, 4'b0000);
        run_vectors("udf");

        // Almost-full at threshold 3, then asynchronous reset mid-stream.
        do_reset(4'd4, 4'd8, 4'd3);
        add(1, 0, 11'hA1, 0, 0, 0, 0, 0, 11'h0, 4'b1110, 0, 4'b0000, 0, 0);
        add(1, 0, 11'hA2, 0, 0, 0, 0, 0, 11'h0, 4'b1110, 0, 4'b0000, 0, 0);
        add(1, 0, 11'hA3, 0, 0, 0, 0, 0, 11'h0, 4'b1110, 0, 4'b0001, 0, 0);
        run_vectors("afull");

        pop = 1'b1; pop_ch = 2'd0;
        @(posedge clk);
        #1;
        check("rst pre pop_valid", 32'(pop_valid), 32'd1);
        check("rst pre pop_data",  32'(pop_data),  32'hA1);
        pop = 1'b0;
        rstn = 1'b0;
        #1;
        check("rst async pop_valid", 32'(pop_valid), 32'd0);
        check("rst async pop_data",  32'(pop_data),  32'd0);
        check_flags("rst async", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        pop = 1'b1; pop_ch = 2'd0;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("rst release pop_valid", 32'(pop_valid), 32'd0);
        check("rst release pop_data",  32'(pop_data),  32'd0);
        check_flags("rst release", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        idle();

        add(1, 0, 11'h3C, 0, 0, 1, 1, 0, 11'h0,  4'b1110, 0, 0, 0, 0);
        add(0, 0, 11'h0,  1, 0, 0, 1, 1, 11'h3C, 4'b1111, 0, 0, 0, 0);
        run_vectors("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_mch_sig.md
# fifo_mch_sig

Multi-channel successor to the single-channel runtime-configured FIFO. It holds NUM_CH independent FIFOs behind one shared write port and one shared read port. Depth and data width are chosen at runtime by stable configuration inputs, up to compile-time maxima. It adds per-channel almost-full flags, a registered read path and sticky overflow/underflow error flags. It sits between the parallel-data producers and the serialiser front end of the p2s path.

## Interface
Parameters:
- max_FIFO_DEPTH, 8, maximum per-channel depth (power of 2)
- max_FIFO_WIDTH, 11, maximum data width
- NUM_CH, 4, number of channels (2..8)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rstn  in  1  reset, asynchronous and active-low
- push  in  1  write strobe
- push_ch  in  $clog2(NUM_CH)  target channel of write
- push_data  in  max_FIFO_WIDTH  write data
- pop  in  1  read strobe
- pop_ch  in  $clog2(NUM_CH)  source channel of read
- pop_data  out  max_FIFO_WIDTH  read data, registered
- pop_valid  out  1  pop_data holds a word popped the previous cycle
- empty  out  NUM_CH  per-channel empty
- full  out  NUM_CH  per-channel full
- afull  out  NUM_CH  per-channel count >= sig_AFULL_THR
- ovf_err  out  NUM_CH  sticky: push to a full channel was dropped
- udf_err  out  NUM_CH  sticky: pop from an empty channel
- err_clr  in  1  clears all sticky error bits
- sig_FIFO_DEPTH  in  4  effective depth; legal values 2, 4, 8 (≤ max_FIFO_DEPTH)
- sig_FIFO_WIDTH  in  4  effective width; legal values 8..11 (≤ max_FIFO_WIDTH)
- sig_AFULL_THR  in  4  almost-full threshold; legal range 1..sig_FIFO_DEPTH

## Operation
- All sig_* inputs are constrained stable and in range while rstn is high. Behaviour under illegal values is undefined.
- Storage is NUM_CH × max_FIFO_DEPTH words. Each channel has its own rd_ptr, wr_ptr and count.
- Pointers wrap at sig_FIFO_DEPTH, not max_FIFO_DEPTH (for example, with depth 4: 0,1,2,3,0).
- Write masking: bits [max_FIFO_WIDTH-1:sig_FIFO_WIDTH] of push_data are stored as 0.
- empty[c] = (count[c] == 0).
- full[c] = (count[c] == sig_FIFO_DEPTH).
- afull[c] = (count[c] >= sig_AFULL_THR).
- Push to a full channel:
  - the data is dropped and no state changes;
  - ovf_err[push_ch] is set;
  - exception: a same-cycle pop on the same channel frees a slot, so the push is accepted and count is unchanged.
- Pop from an empty channel:
  - pointers and count are unchanged;
  - pop_valid is 0 next cycle and udf_err[pop_ch] is set;
  - a same-cycle push to that channel is accepted normally, with no bypass.
- Push and pop on different channels in the same cycle are fully independent.
- Push and pop on the same non-empty, non-full channel in the same cycle: count is unchanged and both pointers advance.
- err_clr has priority over a same-cycle set: the bit reads 0 next cycle.

## Timing
- Reset values, applied asynchronously:
  - all pointers and counts 0;
  - empty all-1s; full, afull, ovf_err, udf_err all 0;
  - pop_valid 0, pop_data 0.
- Read latency is 1: a pop accepted at edge t gives pop_valid = 1 and pop_data at edge t+1.
- pop_valid is 0 in every cycle without an accepted pop. pop_data holds its last value when pop_valid is 0.
- Write-to-read latency is 1: a word pushed at edge t can be popped at edge t+1 and appears on pop_data at edge t+2.
- Flags are combinational from the count registers and therefore reflect pushes and pops one cycle after the strobe.
- Error bits are registered and set at the edge after the offending strobe.
- Reset mid-operation discards all contents immediately. A pop issued in the cycle reset deasserts is treated as underflow.
- Full throughput: one push and one pop every cycle, sustained.

## Structure
- Package fifo_sig_pkg holds:
  - legal depth and width constants (DEPTH_LEGAL 2/4/8, WIDTH_MIN 8, WIDTH_MAX 11);
  - parametrised typedefs ch_idx_t, ptr_t, cnt_t;
  - the width-mask function.
- Sub-module fifo_ch_ctrl is instantiated once per channel via generate. It holds pointers, count, flags and error bits for one channel, given push_en/pop_en and sig_FIFO_DEPTH/sig_AFULL_THR.
- The top level holds the storage array, write masking, the read-data register and the SVA range/stability assumptions.

## Test plan
- Width mask: depth 4, width 8, NUM_CH 4; push ch2 data 0x7FF; pop ch2 -> pop_data 0x0FF one cycle later, pop_valid 1.
- Fill and overflow: depth 4, push ch0 values 1..5 -> full[0] after the 4th push, ovf_err[0] = 1 after the 5th; pops return 1, 2, 3, 4; then empty[0] = 1.
- Wrap-around: depth 2, ten alternating push/pop pairs on ch1 with values 10..19 -> pop order 10..19, count never above 1.
- Simultaneous full push/pop: depth 8, ch3 full; push 0x55 and pop ch3 in the same cycle -> full[3] stays 1, the oldest word is returned, 0x55 is popped eighth; ovf_err[3] stays 0.
- Underflow and error clear: pop the empty ch1 -> pop_valid 0, udf_err[1] = 1; err_clr -> 0; err_clr coincident with a new underflow -> bit reads 0.
- Almost-full and reset: thr 3, depth 4; push 3 words to ch0 -> afull[0] = 1; assert rstn low mid-stream -> empty all-1s and pop_valid 0 immediately, with no stale data after release.
